// File: rtl/bus_fabric_pkg.sv
// Shared constants for the system-bus fabric: CSR map, STATUS bit layout,
// FSM encoding and the default toy-SoC target table.
package bus_fabric_pkg;

    localparam logic [3:0] CSR_FAULT_ADDR = 4'd0;
    localparam logic [3:0] CSR_STATUS     = 4'd1;
    localparam logic [3:0] CSR_CTRL       = 4'd2;

    localparam int ST_VALID = 0;
    localparam int ST_WR    = 1;
    localparam int ST_TMO   = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Target k lives at bits [16k+15:16k] / [5k+4:5k]: RAM, ROM, then four 16-word peripherals.
    localparam int          DEF_N_TGT    = 6;
    localparam logic [95:0] DEF_TGT_BASE = {16'h0430, 16'h0420, 16'h0410, 16'h0400, 16'h2000, 16'h0000};
    localparam logic [29:0] DEF_TGT_SIZE = {5'd4, 5'd4, 5'd4, 5'd4, 5'd10, 5'd10};
    localparam logic [15:0] DEF_CSR_BASE = 16'h0440;
    localparam int          DEF_TIMEOUT  = 16;

endpackage

// File: rtl/bus_fabric_decode.sv
// Combinational address decoder: CSR window first, then the lowest-numbered
// target window containing the address.
module bus_fabric_decode
    import bus_fabric_pkg::*;
#(
    parameter int                   N_TGT    = DEF_N_TGT,
    parameter logic [16*N_TGT-1:0]  TGT_BASE = DEF_TGT_BASE,
    parameter logic [5*N_TGT-1:0]   TGT_SIZE = DEF_TGT_SIZE,
    parameter logic [15:0]          CSR_BASE = DEF_CSR_BASE
) (
    input  logic [15:0]       addr,
    output logic [N_TGT-1:0]  tgt_onehot,
    output logic              tgt_hit,
    output logic              csr_hit
);

    logic [N_TGT-1:0] raw_hit;
    logic             found;

    for (genvar k = 0; k < N_TGT; k++) begin : g_win
        localparam logic [15:0] BASE = TGT_BASE[16*k +: 16];
        localparam logic [4:0]  SIZE = TGT_SIZE[5*k +: 5];
        assign raw_hit[k] = ((addr ^ BASE) >> SIZE) == 16'd0;
    end

    assign csr_hit = (addr[15:4] == CSR_BASE[15:4]);

    always_comb begin
        tgt_onehot = '0;
        found      = 1'b0;
        for (int k = 0; k < N_TGT; k++) begin
            if (raw_hit[k] && !found && !csr_hit) begin
                tgt_onehot[k] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign tgt_hit = |tgt_onehot;

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric: zero-latency decode onto N_TGT targets, ready/wait
// handshake with timeout abort, and a fault-capture CSR window with interrupt.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                   N_TGT    = DEF_N_TGT,
    parameter logic [16*N_TGT-1:0]  TGT_BASE = DEF_TGT_BASE,
    parameter logic [5*N_TGT-1:0]   TGT_SIZE = DEF_TGT_SIZE,
    parameter logic [15:0]          CSR_BASE = DEF_CSR_BASE,
    parameter int                   TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic [15:0]           i_addr,
    input  logic                  i_we,
    input  logic [15:0]           i_wdata,
    output logic [15:0]           o_rdata,
    output logic                  o_ready,
    output logic [N_TGT-1:0]      o_tgt_sel,
    output logic                  o_tgt_we,
    output logic [15:0]           o_tgt_addr,
    output logic [15:0]           o_tgt_wdata,
    input  logic [16*N_TGT-1:0]   i_tgt_rdata,
    input  logic [N_TGT-1:0]      i_tgt_ready,
    output logic                  o_fault_int
);

    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

    logic [N_TGT-1:0] tgt_onehot;
    logic             tgt_hit;
    logic             csr_hit;
    logic [15:0]      sel_rdata;
    logic             sel_ready;
    logic [15:0]      csr_rdata;

    state_t           state;
    logic [7:0]       wait_cnt;

    logic [15:0]      fault_addr;
    logic [3:0]       status;
    logic [3:0]       status_fresh;
    logic             irq_en;

    logic             abort;
    logic             unmapped;
    logic             fault_ev;
    logic             status_clr;
    logic             ctrl_wr;

    bus_fabric_decode #(
        .N_TGT    (N_TGT),
        .TGT_BASE (TGT_BASE),
        .TGT_SIZE (TGT_SIZE),
        .CSR_BASE (CSR_BASE)
    ) u_decode (
        .addr       (i_addr),
        .tgt_onehot (tgt_onehot),
        .tgt_hit    (tgt_hit),
        .csr_hit    (csr_hit)
    );

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int k = 0; k < N_TGT; k++) begin
            if (tgt_onehot[k]) begin
                sel_rdata = i_tgt_rdata[16*k +: 16];
                sel_ready = i_tgt_ready[k];
            end
        end
    end

    always_comb begin
        case (i_addr[3:0])
            CSR_FAULT_ADDR: csr_rdata = fault_addr;
            CSR_STATUS:     csr_rdata = {12'd0, status};
            CSR_CTRL:       csr_rdata = {15'd0, irq_en};
            default:        csr_rdata = '0;
        endcase
    end

    // wait_cnt is nonzero in WAIT and saturates, so TIMEOUT=0 can never match.
    assign abort      = i_req & tgt_hit & (state == ST_WAIT) & (wait_cnt == TMO_CNT);
    assign unmapped   = i_req & ~tgt_hit & ~csr_hit;
    assign fault_ev   = unmapped | abort;
    assign status_clr = i_req & csr_hit & i_we & (i_addr[3:0] == CSR_STATUS) & i_wdata[0];
    assign ctrl_wr    = i_req & csr_hit & i_we & (i_addr[3:0] == CSR_CTRL);

    assign o_ready     = i_req & (csr_hit | unmapped | abort | (tgt_hit & sel_ready));
    assign o_tgt_sel   = (i_req && !abort) ? tgt_onehot : '0;
    assign o_tgt_we    = i_req & i_we & tgt_hit;
    assign o_tgt_addr  = i_addr;
    assign o_tgt_wdata = i_wdata;
    assign o_fault_int = status[ST_VALID] & irq_en;

    always_comb begin
        if (!i_req || abort) begin
            o_rdata = '0;
        end else if (csr_hit) begin
            o_rdata = csr_rdata;
        end else if (tgt_hit) begin
            o_rdata = sel_rdata;
        end else begin
            o_rdata = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req && tgt_hit && !sel_ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (!i_req || o_ready) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        status_fresh           = '0;
        status_fresh[ST_VALID] = 1'b1;
        status_fresh[ST_WR]    = i_we;
        status_fresh[ST_TMO]   = abort;
    end

    // A fault arriving with a clear is captured as a brand-new first fault.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fault_addr <= '0;
            status     <= '0;
            irq_en     <= 1'b0;
        end else begin
            if (fault_ev) begin
                if (!status[ST_VALID] || status_clr) begin
                    fault_addr <= i_addr;
                    status     <= status_fresh;
                end else begin
                    status[ST_OVF] <= 1'b1;
                end
            end else if (status_clr) begin
                status <= '0;
            end
            if (ctrl_wr) begin
                irq_en <= i_wdata[0];
            end
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a transaction-level model.
module tb_bus_fabric;

    localparam int N   = 6;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [15:0]     i_addr;
    logic            i_we;
    logic [15:0]     i_wdata;
    logic [15:0]     o_rdata;
    logic            o_ready;
    logic [N-1:0]    o_tgt_sel;
    logic            o_tgt_we;
    logic [15:0]     o_tgt_addr;
    logic [15:0]     o_tgt_wdata;
    logic [16*N-1:0] i_tgt_rdata;
    logic [N-1:0]    i_tgt_ready;
    logic            o_fault_int;

    always #5 clk = ~clk;

    bus_fabric #(
        .N_TGT    (N),
        .TGT_BASE ({16'h0430, 16'h0420, 16'h0410, 16'h0400, 16'h2000, 16'h0000}),
        .TGT_SIZE ({5'd4, 5'd4, 5'd4, 5'd4, 5'd10, 5'd10}),
        .CSR_BASE (16'h0440),
        .TIMEOUT  (TMO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_we        (i_we),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_ready     (o_ready),
        .o_tgt_sel   (o_tgt_sel),
        .o_tgt_we    (o_tgt_we),
        .o_tgt_addr  (o_tgt_addr),
        .o_tgt_wdata (o_tgt_wdata),
        .i_tgt_rdata (i_tgt_rdata),
        .i_tgt_ready (i_tgt_ready),
        .o_fault_int (o_fault_int)
    );

    logic [15:0] win_base [N] = '{16'h0000, 16'h2000, 16'h0400, 16'h0410, 16'h0420, 16'h0430};
    int          win_size [N] = '{10, 10, 4, 4, 4, 4};

    int          m_wait;
    logic [15:0] m_faddr;
    logic        m_valid, m_wr, m_tmo, m_ovf, m_irq;

    logic [15:0] obs_rdata;
    logic        obs_ready, obs_we, obs_int;
    logic [N-1:0] obs_sel;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_faddr = '0;
        m_valid = 0; m_wr = 0; m_tmo = 0; m_ovf = 0; m_irq = 0;
    endtask

    // -2 = CSR window, -1 = unmapped, otherwise the winning target index
    function automatic int decode(input logic [15:0] a);
        if (a[15:4] == 12'h044) return -2;
        for (int k = 0; k < N; k++)
            if (((a ^ win_base[k]) >> win_size[k]) == 16'd0) return k;
        return -1;
    endfunction

    function automatic logic [15:0] csr_read(input logic [3:0] off);
        case (off)
            4'd0:    return m_faddr;
            4'd1:    return {12'd0, m_ovf, m_tmo, m_wr, m_valid};
            4'd2:    return {15'd0, m_irq};
            default: return 16'd0;
        endcase
    endfunction

    // One bus cycle: compare at the falling edge, advance the model, then step past the rising edge.
    task automatic cycle();
        int           k;
        logic         e_ready, e_we, e_abort, e_fault, e_clr;
        logic [15:0]  e_rdata;
        logic [N-1:0] e_sel;
        @(negedge clk);
        k = decode(i_addr);
        e_ready = 0; e_we = 0; e_abort = 0; e_rdata = '0; e_sel = '0;
        if (i_req) begin
            if (k == -2) begin
                e_ready = 1; e_rdata = csr_read(i_addr[3:0]);
            end else if (k == -1) begin
                e_ready = 1;
            end else if (TMO != 0 && m_wait == TMO) begin
                e_abort = 1; e_ready = 1;
            end else begin
                e_sel   = N'(1 << k);
                e_ready = i_tgt_ready[k];
                e_rdata = i_tgt_rdata[16*k +: 16];
            end
            e_we = i_we && (k >= 0);
        end
        chk("ready", 32'(o_ready), 32'(e_ready));
        chk("rdata", 32'(o_rdata), 32'(e_rdata));
        chk("tgt_sel", 32'(o_tgt_sel), 32'(e_sel));
        chk("tgt_we", 32'(o_tgt_we), 32'(e_we));
        chk("fault_int", 32'(o_fault_int), 32'(m_valid & m_irq));
        chk("tgt_addr", 32'(o_tgt_addr), 32'(i_addr));
        chk("tgt_wdata", 32'(o_tgt_wdata), 32'(i_wdata));
        obs_rdata = o_rdata; obs_ready = o_ready; obs_we = o_tgt_we;
        obs_int = o_fault_int; obs_sel = o_tgt_sel;

        if (i_req && k >= 0 && !e_ready) m_wait = m_wait + 1;
        else m_wait = 0;
        e_fault = i_req && (k == -1 || e_abort);
        e_clr   = i_req && k == -2 && i_we && i_addr[3:0] == 4'd1 && i_wdata[0];
        if (e_fault) begin
            if (!m_valid || e_clr) begin
                m_faddr = i_addr; m_valid = 1; m_wr = i_we; m_tmo = e_abort; m_ovf = 0;
            end else begin
                m_ovf = 1;
            end
        end else if (e_clr) begin
            m_valid = 0; m_wr = 0; m_tmo = 0; m_ovf = 0;
        end
        if (i_req && k == -2 && i_we && i_addr[3:0] == 4'd2) m_irq = i_wdata[0];
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic req, input logic [15:0] addr, input logic we, input logic [15:0] wd);
        i_req = req; i_addr = addr; i_we = we; i_wdata = wd;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return {6'd0, 10'($urandom)};
            1:       return {6'b001000, 10'($urandom)};
            2:       return 16'h0400 + 16'($urandom_range(0, 63));
            3:       return 16'h0440 + 16'($urandom_range(0, 2));
            4:       return 16'h0440 + 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bit active;
        bit hang;

        model_reset();
        rst = 1'b1;
        bus(0, 16'h0000, 0, 16'h0000);
        i_tgt_ready = '0;
        i_tgt_rdata = {$urandom, $urandom, $urandom};
        #2;
        chk("reset_ready", 32'(o_ready), 32'd0);
        chk("reset_sel", 32'(o_tgt_sel), 32'd0);
        chk("reset_rdata", 32'(o_rdata), 32'd0);
        chk("reset_int", 32'(o_fault_int), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();

        // ROM read, zero wait
        bus(1, 16'h2005, 0, 16'h0000);
        i_tgt_ready = 6'b000010;
        i_tgt_rdata[31:16] = 16'hBEEF;
        cycle();
        chk("rom_sel", 32'(obs_sel), 32'h02);
        chk("rom_ready", 32'(obs_ready), 32'd1);
        chk("rom_rdata", 32'(obs_rdata), 32'hBEEF);

        // TIMER write with three wait cycles
        bus(1, 16'h0421, 1, 16'h1234);
        i_tgt_ready = '0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("timer_wait_ready", 32'(obs_ready), 32'd0);
            chk("timer_wait_we", 32'(obs_we), 32'd1);
        end
        i_tgt_ready = 6'b010000;
        cycle();
        chk("timer_done_ready", 32'(obs_ready), 32'd1);
        bus(1, 16'h0441, 0, 16'h0000);
        cycle();
        chk("timer_no_fault", 32'(obs_rdata), 32'h0000);

        // Unmapped read then inspect the capture
        bus(1, 16'h1000, 0, 16'h0000);
        cycle();
        chk("unmapped_ready", 32'(obs_ready), 32'd1);
        chk("unmapped_rdata", 32'(obs_rdata), 32'h0000);
        bus(1, 16'h0441, 0, 16'h0000); cycle();
        chk("status_after_unmapped", 32'(obs_rdata), 32'h0001);
        bus(1, 16'h0440, 0, 16'h0000); cycle();
        chk("faddr_after_unmapped", 32'(obs_rdata), 32'h1000);
        bus(1, 16'h0441, 1, 16'h0001); cycle();
        bus(1, 16'h0442, 1, 16'h0001); cycle();

        // GPIO never ready: abort on the 17th cycle
        bus(1, 16'h0430, 0, 16'h0000);
        i_tgt_ready = '0;
        for (int c = 0; c < TMO; c++) cycle();
        chk("gpio_stall_ready", 32'(obs_ready), 32'd0);
        cycle();
        chk("abort_ready", 32'(obs_ready), 32'd1);
        chk("abort_rdata", 32'(obs_rdata), 32'h0000);
        chk("abort_sel", 32'(obs_sel), 32'h00);
        bus(1, 16'h0441, 0, 16'h0000); cycle();
        chk("status_after_abort", 32'(obs_rdata), 32'h0005);
        chk("int_after_abort", 32'(obs_int), 32'd1);
        bus(1, 16'h0441, 1, 16'h0001); cycle();
        chk("int_during_clear", 32'(obs_int), 32'd1);
        bus(1, 16'h0441, 0, 16'h0000); cycle();
        chk("status_cleared", 32'(obs_rdata), 32'h0000);
        chk("int_cleared", 32'(obs_int), 32'd0);

        // Two unmapped writes: first captured, second overflows
        bus(1, 16'h3000, 1, 16'hAAAA); cycle();
        bus(1, 16'h5000, 1, 16'h5555); cycle();
        bus(1, 16'h0440, 0, 16'h0000); cycle();
        chk("faddr_first_kept", 32'(obs_rdata), 32'h3000);
        bus(1, 16'h0441, 0, 16'h0000); cycle();
        chk("status_ovf", 32'(obs_rdata), 32'h000B);
        bus(1, 16'h0441, 1, 16'h0001); cycle();
        bus(1, 16'h7000, 0, 16'h0000); cycle();
        bus(1, 16'h0441, 0, 16'h0000); cycle();
        chk("status_fresh", 32'(obs_rdata), 32'h0001);
        bus(1, 16'h0440, 0, 16'h0000); cycle();
        chk("faddr_fresh", 32'(obs_rdata), 32'h7000);

        // Reset in the middle of a stalled access
        bus(1, 16'h0430, 0, 16'h0000);
        i_tgt_ready = '0;
        for (int c = 0; c < 4; c++) cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_int", 32'(o_fault_int), 32'd0);
        bus(1, 16'h0441, 0, 16'h0000);
        #1;
        chk("rst_mid_status", 32'(o_rdata), 32'h0000);
        chk("rst_mid_ready", 32'(o_ready), 32'd1);
        bus(0, 16'h0000, 0, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        bus(1, 16'h0430, 0, 16'h0000);
        for (int c = 0; c < 14; c++) cycle();
        chk("fresh_stall_ready", 32'(obs_ready), 32'd0);
        i_tgt_ready = 6'b100000;
        cycle();
        chk("fresh_done_ready", 32'(obs_ready), 32'd1);

        // Randomized traffic
        active = 0;
        hang   = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!active || obs_ready) begin
                bus(($urandom_range(0, 9) != 0), pick_addr(), 1'($urandom), 16'($urandom));
                hang   = ($urandom_range(0, 7) == 0);
                active = i_req;
            end else if ($urandom_range(0, 63) == 0) begin
                i_req  = 1'b0;
                active = 0;
            end
            i_tgt_ready = hang ? '0 : N'($urandom);
            i_tgt_rdata = {$urandom, $urandom, $urandom};
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
